// File: rtl/reg_dbg_pkg.sv
// Shared types and default sizing for the register-file debug controller.
package reg_dbg_pkg;

   localparam int unsigned NUM_REGS_DEF = 32;
   localparam int unsigned ADDR_W_DEF   = 5;
   localparam int unsigned DATA_W_DEF   = 32;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      FILL  = 2'd1,
      DRAIN = 2'd2
   } dump_state_e;

endpackage

// File: rtl/reg_dump_seq.sv
// Register dump sequencer: walks the debug read port and streams each
// register through a single valid/ready output slot.
module reg_dump_seq
   import reg_dbg_pkg::*;
#(
   parameter int unsigned NUM_REGS = NUM_REGS_DEF,
   parameter int unsigned ADDR_W   = ADDR_W_DEF,
   parameter int unsigned DATA_W   = DATA_W_DEF
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   output logic [ADDR_W-1:0] rd_addr,
   input  logic [DATA_W-1:0] rd_data,
   output logic              dump_valid,
   output logic [ADDR_W-1:0] dump_addr,
   output logic [DATA_W-1:0] dump_data,
   input  logic              dump_ready,
   output logic              busy,
   output logic              dump_done
);

   localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NUM_REGS - 1);

   dump_state_e       state_q, state_d;
   logic [ADDR_W-1:0] idx_q, idx_d;
   logic              valid_q, valid_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [DATA_W-1:0] data_q, data_d;
   logic              done_q, done_d;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= IDLE;
         idx_q   <= '0;
         valid_q <= 1'b0;
         addr_q  <= '0;
         data_q  <= '0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         valid_q <= valid_d;
         addr_q  <= addr_d;
         data_q  <= data_d;
         done_q  <= done_d;
      end
   end

   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      valid_d = valid_q;
      addr_d  = addr_q;
      data_d  = data_q;
      done_d  = 1'b0;
      rd_addr = '0;
      unique case (state_q)
         IDLE: begin
            if (start) begin
               state_d = FILL;
               idx_d   = '0;
            end
         end
         FILL: begin
            rd_addr = idx_q;
            // Slot refills in the same cycle its current word is taken.
            if (!valid_q || dump_ready) begin
               valid_d = 1'b1;
               addr_d  = idx_q;
               data_d  = rd_data;
               idx_d   = idx_q + ADDR_W'(1);
               if (idx_q == LAST_IDX) state_d = DRAIN;
            end
         end
         DRAIN: begin
            if (valid_q && dump_ready) begin
               valid_d = 1'b0;
               done_d  = 1'b1;
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   assign dump_valid = valid_q;
   assign dump_addr  = addr_q;
   assign dump_data  = data_q;
   assign dump_done  = done_q;
   assign busy       = (state_q != IDLE);

endmodule

// File: rtl/reg_file_dbg_ctrl.sv
// Debug-side register-file controller: write-port arbitration between core
// writeback and debug host, plus the register snapshot dump sequencer.
module reg_file_dbg_ctrl
   import reg_dbg_pkg::*;
#(
   parameter int unsigned NUM_REGS = NUM_REGS_DEF,
   parameter int unsigned ADDR_W   = ADDR_W_DEF,
   parameter int unsigned DATA_W   = DATA_W_DEF
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              i_core_wr_en,
   input  logic [ADDR_W-1:0] i_core_wr_addr,
   input  logic [DATA_W-1:0] i_core_wr_dat,
   input  logic              i_dbg_wr_valid,
   input  logic [ADDR_W-1:0] i_dbg_wr_addr,
   input  logic [DATA_W-1:0] i_dbg_wr_dat,
   output logic              o_dbg_wr_ready,
   output logic              o_rf_wr_en,
   output logic [ADDR_W-1:0] o_rf_wr_addr,
   output logic [DATA_W-1:0] o_rf_wr_dat,
   output logic [ADDR_W-1:0] o_debug_addr,
   input  logic [DATA_W-1:0] i_debug_data,
   input  logic              i_dump_start,
   output logic              o_dump_valid,
   output logic [ADDR_W-1:0] o_dump_addr,
   output logic [DATA_W-1:0] o_dump_data,
   input  logic              i_dump_ready,
   output logic              o_busy,
   output logic              o_dump_done
);

   logic busy;

   reg_dump_seq #(
      .NUM_REGS (NUM_REGS),
      .ADDR_W   (ADDR_W),
      .DATA_W   (DATA_W)
   ) u_seq (
      .clk        (clk),
      .rst        (rst),
      .start      (i_dump_start),
      .rd_addr    (o_debug_addr),
      .rd_data    (i_debug_data),
      .dump_valid (o_dump_valid),
      .dump_addr  (o_dump_addr),
      .dump_data  (o_dump_data),
      .dump_ready (i_dump_ready),
      .busy       (busy),
      .dump_done  (o_dump_done)
   );

   assign o_busy = busy;

   // Debug writes to x0 are acknowledged but never reach the register file.
   always_comb begin
      o_dbg_wr_ready = 1'b0;
      o_rf_wr_en     = 1'b0;
      o_rf_wr_addr   = i_dbg_wr_addr;
      o_rf_wr_dat    = i_dbg_wr_dat;
      if (i_core_wr_en) begin
         o_rf_wr_en   = 1'b1;
         o_rf_wr_addr = i_core_wr_addr;
         o_rf_wr_dat  = i_core_wr_dat;
      end else begin
         o_dbg_wr_ready = !busy;
         o_rf_wr_en     = i_dbg_wr_valid && !busy && (i_dbg_wr_addr != '0);
      end
   end

endmodule

// File: tb/tb_reg_file_dbg_ctrl.sv
// Self-checking bench for reg_file_dbg_ctrl with a register-file stub and a
// snapshot-based reference model of the dump stream.
module tb_reg_file_dbg_ctrl;

   localparam int unsigned NR = 32;
   localparam int unsigned AW = 5;
   localparam int unsigned DW = 32;

   logic          clk = 1'b0;
   logic          rst = 1'b0;
   logic          i_core_wr_en;
   logic [AW-1:0] i_core_wr_addr;
   logic [DW-1:0] i_core_wr_dat;
   logic          i_dbg_wr_valid;
   logic [AW-1:0] i_dbg_wr_addr;
   logic [DW-1:0] i_dbg_wr_dat;
   logic          o_dbg_wr_ready;
   logic          o_rf_wr_en;
   logic [AW-1:0] o_rf_wr_addr;
   logic [DW-1:0] o_rf_wr_dat;
   logic [AW-1:0] o_debug_addr;
   logic [DW-1:0] i_debug_data;
   logic          i_dump_start;
   logic          o_dump_valid;
   logic [AW-1:0] o_dump_addr;
   logic [DW-1:0] o_dump_data;
   logic          i_dump_ready;
   logic          o_busy;
   logic          o_dump_done;

   logic [DW-1:0] rf_mem [NR];
   logic [DW-1:0] model  [NR];
   logic          rf_init = 1'b1;
   int unsigned   errors = 0;
   int unsigned   checks = 0;

   always #5 clk = ~clk;

   reg_file_dbg_ctrl #(.NUM_REGS(NR), .ADDR_W(AW), .DATA_W(DW)) dut (
      .clk            (clk),
      .rst            (rst),
      .i_core_wr_en   (i_core_wr_en),
      .i_core_wr_addr (i_core_wr_addr),
      .i_core_wr_dat  (i_core_wr_dat),
      .i_dbg_wr_valid (i_dbg_wr_valid),
      .i_dbg_wr_addr  (i_dbg_wr_addr),
      .i_dbg_wr_dat   (i_dbg_wr_dat),
      .o_dbg_wr_ready (o_dbg_wr_ready),
      .o_rf_wr_en     (o_rf_wr_en),
      .o_rf_wr_addr   (o_rf_wr_addr),
      .o_rf_wr_dat    (o_rf_wr_dat),
      .o_debug_addr   (o_debug_addr),
      .i_debug_data   (i_debug_data),
      .i_dump_start   (i_dump_start),
      .o_dump_valid   (o_dump_valid),
      .o_dump_addr    (o_dump_addr),
      .o_dump_data    (o_dump_data),
      .i_dump_ready   (i_dump_ready),
      .o_busy         (o_busy),
      .o_dump_done    (o_dump_done)
   );

   // Register file stub: x0 hardwired to zero, combinational debug read.
   always @(posedge clk) begin
      if (rf_init) begin
         for (int i = 0; i < NR; i++) rf_mem[i] <= '0;
      end else if (o_rf_wr_en && o_rf_wr_addr != '0) begin
         rf_mem[o_rf_wr_addr] <= o_rf_wr_dat;
      end
   end
   assign i_debug_data = rf_mem[o_debug_addr];

   task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %08h expected %08h", tag, obs, exp);
      end
   endtask

   // mode 0: ready held high; 1: random backpressure with refused debug
   // writes and ignored starts; 2: ready high plus core write to x7 as it loads.
   task automatic run_dump(input int mode);
      logic [DW-1:0] snap [NR];
      int unsigned   idx = 0;
      int unsigned   c = 0;
      bit            done = 0;
      bit            stalled = 0;
      logic [AW-1:0] held_addr = '0;
      logic [DW-1:0] held_data = '0;
      for (int i = 0; i < NR; i++) snap[i] = model[i];
      i_dump_start = 1'b1;
      @(negedge clk);
      i_dump_start = 1'b0;
      #1 check("busy_after_start", o_busy, 1);
      while (!done && c < 400) begin
         c++;
         @(negedge clk);
         i_dump_ready = (mode == 1) ? 1'($urandom_range(0, 1)) : 1'b1;
         i_core_wr_en = 1'b0;
         if (mode == 2 && c == 7) begin
            i_core_wr_en   = 1'b1;
            i_core_wr_addr = 5'd7;
            i_core_wr_dat  = 32'hDEADBEEF;
            model[7]       = 32'hDEADBEEF;
         end
         if (mode == 1) begin
            i_dbg_wr_valid = 1'($urandom_range(0, 1));
            i_dbg_wr_addr  = AW'($urandom_range(1, NR - 1));
            i_dbg_wr_dat   = $urandom;
            i_dump_start   = 1'($urandom_range(0, 1));
         end
         #1;
         if (mode == 1 && o_busy) begin
            check("dbg_ready_busy", o_dbg_wr_ready, 0);
            if (i_dbg_wr_valid) check("dbg_wr_blocked", o_rf_wr_en, 0);
         end
         if (mode == 2 && c == 7) begin
            check("rbw_core_en", o_rf_wr_en, 1);
            check("rbw_core_addr", o_rf_wr_addr, 7);
            check("rbw_core_dat", o_rf_wr_dat, 32'hDEADBEEF);
            check("fill_debug_addr", o_debug_addr, 7);
         end
         if (stalled) begin
            check("stall_valid", o_dump_valid, 1);
            check("stall_addr", o_dump_addr, held_addr);
            check("stall_data", o_dump_data, held_data);
         end
         stalled = 0;
         if (o_dump_done) begin
            done = 1;
            i_dump_start   = 1'b0;
            i_dbg_wr_valid = 1'b0;
            check("done_word_count", idx, NR);
            check("busy_at_done", o_busy, 0);
            check("valid_at_done", o_dump_valid, 0);
            if (mode != 1) check("done_cycle", c, 33);
         end else if (o_dump_valid) begin
            if (i_dump_ready) begin
               if (mode != 1) check("word_cycle", c, idx + 1);
               check("dump_addr", o_dump_addr, AW'(idx));
               check("dump_data", o_dump_data, snap[idx % NR]);
               idx++;
            end else begin
               stalled   = 1;
               held_addr = o_dump_addr;
               held_data = o_dump_data;
            end
         end
      end
      i_core_wr_en = 1'b0;
      i_dump_start = 1'b0;
      check("dump_finished", done, 1);
   endtask

   initial begin
      i_core_wr_en   = 1'b0;
      i_core_wr_addr = '0;
      i_core_wr_dat  = '0;
      i_dbg_wr_valid = 1'b0;
      i_dbg_wr_addr  = '0;
      i_dbg_wr_dat   = '0;
      i_dump_start   = 1'b0;
      i_dump_ready   = 1'b1;
      for (int i = 0; i < NR; i++) model[i] = '0;

      repeat (3) @(negedge clk);
      #1;
      check("rst_valid", o_dump_valid, 0);
      check("rst_addr", o_dump_addr, 0);
      check("rst_data", o_dump_data, 0);
      check("rst_busy", o_busy, 0);
      check("rst_done", o_dump_done, 0);
      check("rst_debug_addr", o_debug_addr, 0);
      rf_init = 1'b0;
      rst     = 1'b1;
      @(negedge clk);

      // Preload xk = 0xA0000000 + k through the debug port.
      for (int k = 1; k < NR; k++) begin
         i_dbg_wr_valid = 1'b1;
         i_dbg_wr_addr  = AW'(k);
         i_dbg_wr_dat   = 32'hA000_0000 + DW'(k);
         model[k]       = 32'hA000_0000 + DW'(k);
         #1;
         check("preload_ready", o_dbg_wr_ready, 1);
         check("preload_en", o_rf_wr_en, 1);
         @(negedge clk);
      end
      i_dbg_wr_valid = 1'b0;

      // Core and debug collide: core wins, debug retries next cycle.
      i_core_wr_en   = 1'b1;
      i_core_wr_addr = 5'd3;
      i_core_wr_dat  = 32'h1111_1111;
      i_dbg_wr_valid = 1'b1;
      i_dbg_wr_addr  = 5'd4;
      i_dbg_wr_dat   = 32'h2222_2222;
      model[3]       = 32'h1111_1111;
      #1;
      check("arb_dbg_ready", o_dbg_wr_ready, 0);
      check("arb_core_en", o_rf_wr_en, 1);
      check("arb_core_addr", o_rf_wr_addr, 3);
      check("arb_core_dat", o_rf_wr_dat, 32'h1111_1111);
      @(negedge clk);
      i_core_wr_en = 1'b0;
      model[4]     = 32'h2222_2222;
      #1;
      check("arb_dbg_ready2", o_dbg_wr_ready, 1);
      check("arb_dbg_en", o_rf_wr_en, 1);
      check("arb_dbg_addr", o_rf_wr_addr, 4);
      check("arb_dbg_dat", o_rf_wr_dat, 32'h2222_2222);
      @(negedge clk);

      i_dbg_wr_addr = 5'd0;
      i_dbg_wr_dat  = 32'hFFFF_FFFF;
      #1;
      check("x0_ready", o_dbg_wr_ready, 1);
      check("x0_en", o_rf_wr_en, 0);
      @(negedge clk);
      i_dbg_wr_valid = 1'b0;

      // Two full dumps back to back: the second start lands at edge N+34.
      run_dump(0);
      run_dump(0);
      @(negedge clk);
      #1;
      check("done_single_pulse", o_dump_done, 0);
      check("idle_busy", o_busy, 0);

      // Random mixed writes update the model by the arbitration rules.
      for (int n = 0; n < 40; n++) begin
         @(negedge clk);
         i_core_wr_en   = 1'($urandom_range(0, 1));
         i_core_wr_addr = AW'($urandom_range(0, NR - 1));
         i_core_wr_dat  = $urandom;
         i_dbg_wr_valid = 1'($urandom_range(0, 1));
         i_dbg_wr_addr  = AW'($urandom_range(0, NR - 1));
         i_dbg_wr_dat   = $urandom;
         if (i_core_wr_en) begin
            if (i_core_wr_addr != '0) model[i_core_wr_addr] = i_core_wr_dat;
         end else if (i_dbg_wr_valid && i_dbg_wr_addr != '0) begin
            model[i_dbg_wr_addr] = i_dbg_wr_dat;
         end
         #1 check("rand_dbg_ready", o_dbg_wr_ready, !i_core_wr_en);
      end
      @(negedge clk);
      i_core_wr_en   = 1'b0;
      i_dbg_wr_valid = 1'b0;

      run_dump(1);
      run_dump(2);
      run_dump(0);

      // Reset while word 5 is presented aborts the dump silently.
      @(negedge clk);
      i_dump_ready = 1'b1;
      i_dump_start = 1'b1;
      @(negedge clk);
      i_dump_start = 1'b0;
      repeat (6) @(negedge clk);
      #1 check("pre_rst_word", o_dump_addr, 5);
      rst = 1'b0;
      #1;
      check("mid_rst_valid", o_dump_valid, 0);
      check("mid_rst_addr", o_dump_addr, 0);
      check("mid_rst_data", o_dump_data, 0);
      check("mid_rst_busy", o_busy, 0);
      check("mid_rst_done", o_dump_done, 0);
      check("mid_rst_debug_addr", o_debug_addr, 0);
      repeat (2) begin
         @(negedge clk);
         #1 check("rst_hold_done", o_dump_done, 0);
      end
      rst = 1'b1;
      repeat (3) begin
         @(negedge clk);
         #1;
         check("post_rst_busy", o_busy, 0);
         check("post_rst_valid", o_dump_valid, 0);
         check("post_rst_done", o_dump_done, 0);
      end
      run_dump(0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/reg_file_dbg_ctrl.md
# reg_file_dbg_ctrl

Debug-side controller for the processor register file. Shares the register-file write port between the core writeback path and a debug host, and sequences the register-file debug read port to stream a snapshot of all registers out over a valid/ready interface. Sits between the core/debug host and `reg_file`, driving its write port and its debug address.

## Interface
- `NUM_REGS`, 32: registers dumped, addresses 0..NUM_REGS-1
- `ADDR_W`, 5: register address width, must satisfy 2**ADDR_W >= NUM_REGS
- `DATA_W`, 32: register data width

- `clk`  in  1  single clock; all state changes on rising edge
- `rst`  in  1  reset, asynchronous, active-low
- `i_core_wr_en`, `i_core_wr_addr`, `i_core_wr_dat`  in  1/ADDR_W/DATA_W  core writeback request
- `i_dbg_wr_valid`, `i_dbg_wr_addr`, `i_dbg_wr_dat`  in  1/ADDR_W/DATA_W  debug write request
- `o_dbg_wr_ready`  out  1  debug write accepted this cycle
- `o_rf_wr_en`, `o_rf_wr_addr`, `o_rf_wr_dat`  out  1/ADDR_W/DATA_W  to reg_file write port
- `o_debug_addr`  out  ADDR_W  to reg_file debug read address
- `i_debug_data`  in  DATA_W  from reg_file debug read data, combinational
- `i_dump_start`  in  1  request full dump; sampled only in IDLE
- `o_dump_valid`, `o_dump_addr`, `o_dump_data`  out  1/ADDR_W/DATA_W  dump output slot
- `i_dump_ready`  in  1  dump consumer ready
- `o_busy`  out  1  dump in progress
- `o_dump_done`  out  1  one-cycle pulse after last word handshaken

## Operation
- Write arbitration, combinational: core has absolute priority.
  - `i_core_wr_en`=1: rf port = core request; `o_dbg_wr_ready`=0.
  - else `o_dbg_wr_ready` = !o_busy; rf port = debug request when `i_dbg_wr_valid && o_dbg_wr_ready`.
  - Debug write to address 0: accepted (ready=1) but `o_rf_wr_en`=0; x0 stays zero.
  - Debug writes blocked during dump (snapshot consistency); core writes never blocked.
- FSM states: IDLE, FILL, DRAIN.
  - IDLE: `i_dump_start`=1 → FILL, index counter := 0, `o_busy`:=1.
  - FILL: `o_debug_addr` = index. Slot loads when `!o_dump_valid || i_dump_ready`: data := `i_debug_data`, addr := index, valid := 1, index++. Loading index NUM_REGS-1 → DRAIN.
  - DRAIN: on `o_dump_valid && i_dump_ready` → IDLE, valid:=0, busy:=0, `o_dump_done` pulses 1 cycle.
  - Outside FILL, `o_debug_addr` = 0.
- Slot contents stable while `o_dump_valid && !i_dump_ready`; no word dropped or duplicated.
- A core write to register k in the same cycle k is loaded yields the pre-write value (read-before-write).
- `i_dump_start` outside IDLE ignored; not queued.

## Timing
- Reset (asynchronous assert, synchronous-safe release): state IDLE, index 0, `o_dump_valid`/`o_busy`/`o_dump_done` 0, `o_dump_addr`/`o_dump_data` 0. Combinational outputs follow inputs.
- Reset mid-dump: aborts immediately, no done pulse, no further words.
- Start sampled at edge N: `o_busy` high after N; word 0 valid after N+1.
- Ready held high: one word/cycle; word 31 valid after N+32; done pulse in cycle after N+33; `o_busy` low same cycle as pulse; new start accepted at edge N+34.
- Ready low: FILL stalls, index holds; resumes same cycle ready returns.
- Write arbitration zero latency; reg_file commits on following edge.

## Structure
- Package `reg_dbg_pkg`: state enum (IDLE, FILL, DRAIN), default NUM_REGS/ADDR_W/DATA_W constants.
- One sub-module natural: `reg_dump_seq` (FSM, index counter, output slot); arbitration mux stays in top.

## Test plan
- Reset: hold `rst`=0 mid-dump at word 5 → all outputs 0, no `o_dump_done`; after release, state IDLE.
- Arbitration: core wr x3=0x11111111 with debug wr x4=0x22222222 same cycle → rf gets x3, `o_dbg_wr_ready`=0; next cycle debug accepted, x4=0x22222222.
- x0 protection: debug wr x0=0xFFFFFFFF → ready=1, `o_rf_wr_en`=0; dump word 0 = 0x00000000.
- Full dump, ready high: preload xk=0xA0000000+k → 32 words, addr 0..31 in order, data match, done pulse at N+34 cycle, busy low.
- Backpressure: ready toggling 1-0-0-1 random → each word exactly once, data stable while stalled; debug writes refused while busy; start during busy ignored.
- Read-before-write: core writes x7=0xDEADBEEF in cycle word 7 loads → dump reports old x7; subsequent dump reports 0xDEADBEEF.
